// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder controller.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_serial_add_ctrl_if.sv
// Operand/result handshake bundle for cla_serial_add_ctrl.
interface cla_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             grp_p;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, grp_p
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, grp_p
    );
endinterface

// File: rtl/cla_serial_add_ctrl_bit_4_augment.sv
// 4-bit carry-lookahead slice: nibble sum plus group propagate/generate for chaining.
module bit_4_augment (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       p,
    output logic       g
);
    logic [3:0] pb;
    logic [3:0] gb;
    logic [3:0] c;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign pb[gi]  = a[gi] ^ b[gi];
            assign gb[gi]  = a[gi] & b[gi];
            assign sum[gi] = pb[gi] ^ c[gi];
        end
    endgenerate

    // Flat lookahead carries; no ripple through the slice.
    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & cin);

    assign p = &pb;
    assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);
endmodule

// File: rtl/cla_serial_add_ctrl.sv
// WIDTH-bit add/subtract by walking one 4-bit lookahead slice over the operands, LSB nibble first.
module cla_serial_add_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_serial_add_ctrl_if.slave  bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t                state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [WIDTH-1:0]      a_reg;
    logic [WIDTH-1:0]      b_reg;
    logic [WIDTH-1:0]      sum_reg;
    logic                  carry_reg;
    logic                  p_acc_reg;
    logic                  cout_reg;
    logic                  ovf_reg;
    logic                  grp_p_reg;
    logic                  out_valid_reg;

    logic [NIBBLE_W-1:0]   slice_a;
    logic [NIBBLE_W-1:0]   slice_b;
    logic [NIBBLE_W-1:0]   slice_sum;
    logic                  slice_p;
    logic                  slice_g;
    logic                  carry_next;
    logic                  p_acc_next;

    assign slice_a = a_reg[idx_reg*NIBBLE_W +: NIBBLE_W];
    assign slice_b = b_reg[idx_reg*NIBBLE_W +: NIBBLE_W];

    bit_4_augment u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_reg),
        .sum (slice_sum),
        .p   (slice_p),
        .g   (slice_g)
    );

    assign carry_next = slice_g | (slice_p & carry_reg);
    assign p_acc_next = p_acc_reg & slice_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            p_acc_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            grp_p_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract as A + ~B + 1: the +1 enters as the first carry-in.
                        a_reg     <= bus.a;
                        b_reg     <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub;
                        idx_reg   <= '0;
                        p_acc_reg <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx_reg*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                    carry_reg <= carry_next;
                    p_acc_reg <= p_acc_next;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg      <= carry_next;
                        grp_p_reg     <= p_acc_next;
                        ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                       & (slice_sum[NIBBLE_W-1] != a_reg[WIDTH-1]);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.grp_p     = grp_p_reg;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl at WIDTH=16 with hand-computed expected results.
module tb_cla_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cla_serial_add_ctrl_if #(.WIDTH(16)) bus ();

    cla_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Drives one operation from an IDLE sample point and returns what was observed.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] sum, output logic cout, output logic ovf,
                         output logic gp, output int lat, output logic ready_in_run);
        bus.a = a; bus.b = b; bus.sub = s; bus.in_valid = 1'b1;
        ready_in_run = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) ready_in_run = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        sum = bus.sum; cout = bus.cout; ovf = bus.ovf; gp = bus.grp_p;
        $display("op a=%h b=%h sub=%0b -> sum=%h cout=%0b ovf=%0b grp_p=%0b lat=%0d",
                 a, b, s, sum, cout, ovf, gp, lat);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
        checks++; if ({bus.cout, bus.ovf, bus.grp_p} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {bus.cout, bus.ovf, bus.grp_p}); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_add_basic();
        logic [15:0] s; logic c, o, p, r; int lat;
        do_op(16'h1234, 16'h0FF0, 1'b0, s, c, o, p, lat, r);
        checks++; if (s !== 16'h2224) begin errors++; $display("FAIL add_basic_sum got=%h exp=2224", s); end
        checks++; if ({c, o} !== 2'b00) begin errors++; $display("FAIL add_basic_cout_ovf got=%b exp=00", {c, o}); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_basic_latency got=%0d exp=4", lat); end
        checks++; if (r !== 1'b0) begin errors++; $display("FAIL add_basic_in_ready_in_run got=%b exp=0", r); end
    endtask

    task automatic test_propagate();
        logic [15:0] s; logic c, o, p, r; int lat;
        do_op(16'hAAAA, 16'h5555, 1'b0, s, c, o, p, lat, r);
        checks++; if (s !== 16'hFFFF) begin errors++; $display("FAIL prop_sum got=%h exp=ffff", s); end
        checks++; if ({c, o, p} !== 3'b001) begin errors++; $display("FAIL prop_flags got=%b exp=001", {c, o, p}); end
        do_op(16'hFFFF, 16'h0001, 1'b0, s, c, o, p, lat, r);
        checks++; if (s !== 16'h0000) begin errors++; $display("FAIL wrap_sum got=%h exp=0000", s); end
        checks++; if ({c, o, p} !== 3'b100) begin errors++; $display("FAIL wrap_flags got=%b exp=100", {c, o, p}); end
    endtask

    task automatic test_overflow();
        logic [15:0] s; logic c, o, p, r; int lat;
        do_op(16'h7FFF, 16'h0001, 1'b0, s, c, o, p, lat, r);
        checks++; if (s !== 16'h8000) begin errors++; $display("FAIL ovf_add_sum got=%h exp=8000", s); end
        checks++; if ({c, o} !== 2'b01) begin errors++; $display("FAIL ovf_add_flags got=%b exp=01", {c, o}); end
        do_op(16'h8000, 16'h0001, 1'b1, s, c, o, p, lat, r);
        checks++; if (s !== 16'h7FFF) begin errors++; $display("FAIL ovf_sub_sum got=%h exp=7fff", s); end
        checks++; if ({c, o} !== 2'b11) begin errors++; $display("FAIL ovf_sub_flags got=%b exp=11", {c, o}); end
    endtask

    task automatic test_borrow();
        logic [15:0] s; logic c, o, p, r; int lat;
        do_op(16'h0005, 16'h0007, 1'b1, s, c, o, p, lat, r);
        checks++; if (s !== 16'hFFFE) begin errors++; $display("FAIL borrow_sum got=%h exp=fffe", s); end
        checks++; if ({c, o} !== 2'b00) begin errors++; $display("FAIL borrow_flags got=%b exp=00", {c, o}); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL borrow_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.a = 16'h0102; bus.b = 16'h0304; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 16'h1111; bus.b = 16'h2222;  // next op offered while busy
        lat = 0;
        while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL stall_latency got=%0d exp=4", lat); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.sum !== 16'h0406) begin errors++; $display("FAIL stall_sum cyc=%0d got=%h exp=0406", i, bus.sum); end
            checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL stall_hs cyc=%0d got=%b exp=10", i, {bus.out_valid, bus.in_ready}); end
            @(posedge clk); #1;
        end
        $display("stall op sum=%h held, releasing", bus.sum);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL release_hs got=%b exp=01", {bus.out_valid, bus.in_ready}); end
        @(posedge clk); #1;  // accept edge of the waiting op
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL next_accept in_ready got=%b exp=0", bus.in_ready); end
        lat = 0;
        while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        $display("queued op a=1111 b=2222 -> sum=%h lat=%0d", bus.sum, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL next_latency got=%0d exp=4", lat); end
        checks++; if (bus.sum !== 16'h3333) begin errors++; $display("FAIL next_sum got=%h exp=3333", bus.sum); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s; logic c, o, p, r; int lat;
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;  // accept
        bus.in_valid = 1'b0;
        @(posedge clk); #1;  // second RUN cycle
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum got=%h exp=0000", bus.sum); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL postrst_in_ready got=%b exp=1", bus.in_ready); end
        do_op(16'h0001, 16'h0002, 1'b0, s, c, o, p, lat, r);
        checks++; if (s !== 16'h0003) begin errors++; $display("FAIL postrst_sum got=%h exp=0003", s); end
        checks++; if ({c, o, p} !== 3'b000) begin errors++; $display("FAIL postrst_flags got=%b exp=000", {c, o, p}); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL postrst_latency got=%0d exp=4", lat); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_add_basic();
        test_propagate();
        test_overflow();
        test_borrow();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
